// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 16;
  localparam int FIFO_DEF_DEPTH = 16;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // Occupancy width: must represent 0..depth inclusive.
  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int pw_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one synchronous read port with a
// registered output. Contents are never reset; only the read register is.
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty
// thresholds and sticky overflow/underflow flags.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_DEF_WIDTH,
  parameter int DEPTH     = FIFO_DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  localparam int CW       = cw_of(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wpush,
  input  logic [WIDTH-1:0] wdata,
  output logic             wfull,
  output logic             almost_full,
  input  logic             rpop,
  output logic [WIDTH-1:0] rdata,
  output logic             rempty,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int PW = pw_of(DEPTH);

  logic [PW-1:0] wptr_reg, wptr_next;
  logic [PW-1:0] rptr_reg, rptr_next;
  logic [CW-1:0] count_reg, count_next;
  fifo_err_t     err_reg, err_next;
  logic          push_ok, pop_ok;

  // Flags decode only the registered count, so they move strictly after an edge.
  assign wfull        = (count_reg == CW'(DEPTH));
  assign rempty       = (count_reg == '0);
  assign almost_full  = (int'(count_reg) >= AFULL_TH);
  assign almost_empty = (int'(count_reg) <= AEMPTY_TH);
  assign count        = count_reg;
  assign overflow     = err_reg.overflow;
  assign underflow    = err_reg.underflow;

  always_comb begin
    push_ok    = wpush & ~wfull;
    pop_ok     = rpop & ~rempty;
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    count_next = count_reg;
    err_next   = err_reg;

    if (push_ok) begin
      wptr_next = PW'(ptr_inc(32'(wptr_reg), DEPTH));
    end
    if (pop_ok) begin
      rptr_next = PW'(ptr_inc(32'(rptr_reg), DEPTH));
    end

    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    // A new rejection in the same cycle as clr_err keeps the flag set.
    err_next.overflow  = (err_reg.overflow  & ~clr_err) | (wpush & wfull);
    err_next.underflow = (err_reg.underflow & ~clr_err) | (rpop & rempty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      err_reg   <= '0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push_ok & ~rst),
    .waddr (wptr_reg),
    .wdata (wdata),
    .re    (pop_ok & ~rst),
    .raddr (rptr_reg),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_fifo_sync.sv
// Randomised scoreboard bench for fifo_sync at DEPTH=16/WIDTH=16 and DEPTH=5/WIDTH=8.
module tb_fifo_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // DUT 0: DEPTH 16, WIDTH 16, thresholds 14 / 2
  logic        rst1 = 1'b1, wpush1 = 1'b0, rpop1 = 1'b0, clr1 = 1'b0;
  logic [15:0] wdata1 = '0, rdata1;
  logic        wfull1, afull1, rempty1, aempty1, ovf1, unf1;
  logic [4:0]  count1;

  // DUT 1: DEPTH 5, WIDTH 8, thresholds 4 / 1
  logic        rst2 = 1'b1, wpush2 = 1'b0, rpop2 = 1'b0, clr2 = 1'b0;
  logic [7:0]  wdata2 = '0, rdata2;
  logic        wfull2, afull2, rempty2, aempty2, ovf2, unf2;
  logic [2:0]  count2;

  fifo_sync #(.WIDTH(16), .DEPTH(16)) dut1 (
    .clk(clk), .rst(rst1), .wpush(wpush1), .wdata(wdata1), .wfull(wfull1),
    .almost_full(afull1), .rpop(rpop1), .rdata(rdata1), .rempty(rempty1),
    .almost_empty(aempty1), .count(count1), .overflow(ovf1), .underflow(unf1),
    .clr_err(clr1)
  );

  fifo_sync #(.WIDTH(8), .DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1)) dut2 (
    .clk(clk), .rst(rst2), .wpush(wpush2), .wdata(wdata2), .wfull(wfull2),
    .almost_full(afull2), .rpop(rpop2), .rdata(rdata2), .rempty(rempty2),
    .almost_empty(aempty2), .count(count2), .overflow(ovf2), .underflow(unf2),
    .clr_err(clr2)
  );

  // Reference model: FIFO contents as a queue, plus the last popped word and sticky errors.
  logic [15:0] mq[$];
  logic [15:0] exp_q[$];
  logic [15:0] m_rdata = '0;
  bit          m_ov = 1'b0, m_un = 1'b0;

  function automatic void chk(input int k, input string name,
                              input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0h expected %0h", k, name, act, exp);
    end
  endfunction

  // Monitors: whenever a DUT accepts a pop, the next rdata must be the scoreboard head.
  always @(posedge clk) begin
    if (!rst1 && rpop1 && !rempty1) begin
      #1;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut0 pop_unexpected: got %0h expected none", rdata1);
      end else begin
        $display("dut0 pop data=%04h", rdata1);
        chk(0, "pop_data", 32'(rdata1), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(posedge clk) begin
    if (!rst2 && rpop2 && !rempty2) begin
      #1;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut1 pop_unexpected: got %0h expected none", rdata2);
      end else begin
        $display("dut1 pop data=%02h", rdata2);
        chk(1, "pop_data", 32'(rdata2), 32'(exp_q.pop_front()));
      end
    end
  end

  // One clock of stimulus on DUT k, with the model advanced from pre-edge state.
  task automatic cyc(input int k, input bit push, input logic [15:0] d,
                     input bit pop, input bit clr, input bit r);
    int dep, af, ae, sz;
    bit full, empty;
    logic [31:0] a_cnt, a_rd;
    logic a_full, a_empty, a_af, a_ae, a_ov, a_un;
    dep = (k == 0) ? 16 : 5;
    af  = (k == 0) ? 14 : 4;
    ae  = (k == 0) ? 2 : 1;
    if (k != 0) d = {8'h00, d[7:0]};
    if (k == 0) begin
      wpush1 = push; wdata1 = d; rpop1 = pop; clr1 = clr; rst1 = r;
    end else begin
      wpush2 = push; wdata2 = d[7:0]; rpop2 = pop; clr2 = clr; rst2 = r;
    end
    if (r) begin
      mq.delete(); m_rdata = '0; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      sz = mq.size();
      full = (sz == dep);
      empty = (sz == 0);
      m_ov = (m_ov && !clr) || (push && full);
      m_un = (m_un && !clr) || (pop && empty);
      if (pop && !empty) begin
        m_rdata = mq.pop_front();
        exp_q.push_back(m_rdata);
      end
      if (push && !full) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    if (k == 0) begin
      a_cnt = 32'(count1); a_rd = 32'(rdata1); a_full = wfull1; a_empty = rempty1;
      a_af = afull1; a_ae = aempty1; a_ov = ovf1; a_un = unf1;
      wpush1 = 1'b0; rpop1 = 1'b0; clr1 = 1'b0; rst1 = 1'b0;
    end else begin
      a_cnt = 32'(count2); a_rd = 32'(rdata2); a_full = wfull2; a_empty = rempty2;
      a_af = afull2; a_ae = aempty2; a_ov = ovf2; a_un = unf2;
      wpush2 = 1'b0; rpop2 = 1'b0; clr2 = 1'b0; rst2 = 1'b0;
    end
    sz = mq.size();
    chk(k, "count", a_cnt, 32'(sz));
    chk(k, "count_bound", 32'(a_cnt <= 32'(dep)), 32'd1);
    chk(k, "wfull", 32'(a_full), 32'(sz == dep));
    chk(k, "rempty", 32'(a_empty), 32'(sz == 0));
    chk(k, "almost_full", 32'(a_af), 32'(sz >= af));
    chk(k, "almost_empty", 32'(a_ae), 32'(sz <= ae));
    chk(k, "overflow", 32'(a_ov), 32'(m_ov));
    chk(k, "underflow", 32'(a_un), 32'(m_un));
    chk(k, "rdata_hold", a_rd, 32'(m_rdata));
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 20 && mq.size() > 0; i++) cyc(k, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // DUT 0: reset, with push/pop asserted in the reset cycle (ignored)
    cyc(0, 1'b1, 16'hdead, 1'b1, 1'b0, 1'b1);
    cyc(0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Fill 1..16, then a rejected 17th push
    for (int i = 1; i <= 16; i++) cyc(0, 1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b1, 16'h0099, 1'b0, 1'b0, 1'b0);

    // Pop all 16, then a rejected pop (rdata holds 16)
    for (int i = 0; i < 16; i++) cyc(0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Steady state at count 5 with simultaneous push+pop
    for (int i = 0; i < 5; i++) cyc(0, 1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    repeat (100) cyc(0, 1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
    drain(0);

    // Push+pop while full: push rejected, its word never appears
    for (int i = 0; i < 16; i++) cyc(0, 1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b1, 16'haaaa, 1'b1, 1'b0, 1'b0);
    drain(0);
    cyc(0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Random traffic, push-heavy then pop-heavy to visit both boundaries
    repeat (150) cyc(0, $urandom_range(0, 9) < 7, 16'($urandom),
                     $urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0, 1'b0);
    repeat (150) cyc(0, $urandom_range(0, 9) < 3, 16'($urandom),
                     $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, 1'b0);

    // Mid-operation reset discards contents; next word comes back fresh
    for (int i = 0; i < 3; i++) cyc(0, 1'b1, 16'h0b00 + 16'(i), 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b1, 16'hbeef, 1'b1, 1'b0, 1'b1);
    cyc(0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // clr_err together with a rejected push leaves overflow set
    for (int i = 0; i < 16; i++) cyc(0, 1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b0);
    drain(0);
    chk(0, "scoreboard_left", 32'(exp_q.size()), 32'd0);

    // DUT 1 (DEPTH 5): reset, prime 3 words, 20 push+pop cycles wrap pointers 4 times
    cyc(1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1, 1'b1, 16'(8'hc0 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1, 1'b1, 16'(8'h10 + i), 1'b1, 1'b0, 1'b0);
    repeat (120) cyc(1, $urandom_range(0, 1) == 1, 16'($urandom),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, 1'b0);
    drain(1);
    chk(1, "scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
